// File: rtl/instr_mem_access.sv
// Memory-access stage: performs LOAD/STORE on a req/ack data-memory port and registers the result for write-back.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses with mem_err.
`ifndef XLEN
`define XLEN 32
`endif

module instr_mem_access #(
    parameter int XLEN    = `XLEN,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            valid_out,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_en,
    output logic [4:0]      rd_out,
    output logic            mem_err,
    output logic            bus_err
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q;
    logic            req_q, we_q, valid_q, wb_en_q, mem_err_q, bus_err_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] addr_q, wdata_q, instr_out_q, wb_data_q;
    logic [XLEN-1:0] acc_instr_q, acc_alu_q;
    logic [7:0]      cnt_q;

    function automatic logic wb_ok(input logic [6:0] opc, input logic [4:0] rd);
        return (opc inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD})
            && (rd != 5'd0);
    endfunction

    logic [6:0] opc_in;
    logic [2:0] f3_in;
    logic       is_load_in, is_store_in, is_mem_in;
    assign opc_in      = instruction_in[6:0];
    assign f3_in       = instruction_in[14:12];
    assign is_load_in  = (opc_in == OPC_LOAD);
    assign is_store_in = (opc_in == OPC_STORE);
    assign is_mem_in   = is_load_in | is_store_in;

    logic            f3_ok_d, misalign_d, access_ok_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] wdata_d;

    always_comb begin
        case (f3_in)
            3'b000, 3'b001, 3'b010: f3_ok_d = 1'b1;
            3'b100, 3'b101:         f3_ok_d = is_load_in;
            default:                f3_ok_d = 1'b0;
        endcase
        misalign_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (f3_in[1:0])
            2'b01:   misalign_d = alu_in[0];
            2'b10:   misalign_d = |alu_in[1:0];
            default: misalign_d = 1'b0;
        endcase
`endif
        access_ok_d = is_mem_in & f3_ok_d & ~misalign_d;
        // Store lane placement: data is replicated, strobes pick the live lanes.
        case (f3_in[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << alu_in[1:0];
                wdata_d = {4{mem_data_in[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << {alu_in[1], 1'b0};
                wdata_d = {2{mem_data_in[15:0]}};
            end
            default: begin
                wstrb_d = 4'b1111;
                wdata_d = mem_data_in;
            end
        endcase
    end

    logic [7:0]      byte_d;
    logic [15:0]     half_d;
    logic [XLEN-1:0] load_fmt_d;
    logic            timeout_hit;

    always_comb begin
        byte_d = dmem_rdata[{acc_alu_q[1:0], 3'b000} +: 8];
        half_d = acc_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (acc_instr_q[14:12])
            3'b000:  load_fmt_d = {{(XLEN-8){byte_d[7]}}, byte_d};
            3'b001:  load_fmt_d = {{(XLEN-16){half_d[15]}}, half_d};
            3'b100:  load_fmt_d = {{(XLEN-8){1'b0}}, byte_d};
            3'b101:  load_fmt_d = {{(XLEN-16){1'b0}}, half_d};
            default: load_fmt_d = dmem_rdata;
        endcase
    end

    // An ack on the limit cycle masks the abort, so completion wins the tie.
    assign timeout_hit = (state_q == ACCESS) && !dmem_ack && (cnt_q == 8'(TIMEOUT - 1));
    assign stall_out   = ((state_q == IDLE) && valid_in && access_ok_d)
                       || ((state_q == ACCESS) && !dmem_ack && !timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            valid_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            wstrb_q     <= 4'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            instr_out_q <= '0;
            wb_data_q   <= '0;
            acc_instr_q <= '0;
            acc_alu_q   <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_err_q <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in && access_ok_d) begin
                        state_q     <= ACCESS;
                        req_q       <= 1'b1;
                        we_q        <= is_store_in;
                        addr_q      <= {alu_in[XLEN-1:2], 2'b00};
                        wstrb_q     <= is_store_in ? wstrb_d : 4'b0;
                        wdata_q     <= is_store_in ? wdata_d : '0;
                        acc_instr_q <= instruction_in;
                        acc_alu_q   <= alu_in;
                        cnt_q       <= '0;
                    end else if (valid_in) begin
                        // Non-memory ops pass through; illegal memory ops complete here with mem_err.
                        valid_q     <= 1'b1;
                        instr_out_q <= instruction_in;
                        wb_data_q   <= alu_in;
                        mem_err_q   <= is_mem_in;
                        wb_en_q     <= !is_mem_in && wb_ok(opc_in, instruction_in[11:7]);
                    end
                end
                ACCESS: begin
                    if (dmem_ack || timeout_hit) begin
                        state_q     <= IDLE;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        wstrb_q     <= 4'b0;
                        valid_q     <= 1'b1;
                        instr_out_q <= acc_instr_q;
                        wb_data_q   <= (dmem_ack && acc_instr_q[6:0] == OPC_LOAD) ? load_fmt_d : acc_alu_q;
                        bus_err_q   <= !dmem_ack;
                        wb_en_q     <= dmem_ack && wb_ok(acc_instr_q[6:0], acc_instr_q[11:7]);
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wstrb      = wstrb_q;
    assign dmem_wdata      = wdata_q;
    assign valid_out       = valid_q;
    assign instruction_out = instr_out_q;
    assign wb_data         = wb_data_q;
    assign wb_en           = wb_en_q;
    assign rd_out          = instr_out_q[11:7];
    assign mem_err         = mem_err_q;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_instr_mem_access.sv
// Table-driven bench for instr_mem_access with a write-back scoreboard and a scripted memory responder.
`timescale 1ns/1ps
module tb_instr_mem_access;
    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst, valid_in, dmem_ack;
    logic [XLEN-1:0] instruction_in, alu_in, mem_data_in, dmem_rdata;
    logic            stall_out, dmem_req, dmem_we, valid_out, wb_en, mem_err, bus_err;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, instruction_out, wb_data;
    logic [3:0]      dmem_wstrb;
    logic [4:0]      rd_out;

    instr_mem_access #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instruction_in(instruction_in),
        .alu_in(alu_in), .mem_data_in(mem_data_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .valid_out(valid_out), .instruction_out(instruction_out),
        .wb_data(wb_data), .wb_en(wb_en), .rd_out(rd_out), .mem_err(mem_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, alu, sdata, rdata;
        int          delay;       // ack delay after req rises, -1 = never
        logic        access;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] wb;
        logic        chk_data, wb_en, merr, berr;
    } vec_t;

    typedef struct {
        logic [31:0] instr, wb;
        logic        chk_data, wb_en, merr, berr;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] itype(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {12'h000, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] stype(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, alu, sdata, rdata, input int delay,
                                input logic access, input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic we, input logic [31:0] wdata, input logic [31:0] wb,
                                input logic chk_data, wbe, merr, berr);
        vec_t v;
        v.instr = instr; v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.delay = delay;
        v.access = access; v.addr = addr; v.wstrb = wstrb; v.we = we; v.wdata = wdata;
        v.wb = wb; v.chk_data = chk_data; v.wb_en = wbe; v.merr = merr; v.berr = berr;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] instr, wb, input logic chk_data, wbe, merr, berr);
        exp_t e;
        e.instr = instr; e.wb = wb; e.chk_data = chk_data; e.wb_en = wbe; e.merr = merr; e.berr = berr;
        sb.push_back(e);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        $display("vec %0d instr=%h alu=%h access=%0d delay=%0d", idx, v.instr, v.alu, v.access, v.delay);
        push_exp(v.instr, v.wb, v.chk_data, v.wb_en, v.merr, v.berr);
        @(posedge clk); #1;
        valid_in = 1'b1; instruction_in = v.instr; alu_in = v.alu; mem_data_in = v.sdata;
        dmem_ack = 1'b0; dmem_rdata = v.rdata;
        @(negedge clk);
        check("stall_issue", 32'(stall_out), 32'(v.access));
        @(posedge clk); #1;
        valid_in = 1'b0;
        if (!v.access) begin
            @(negedge clk);
            check("no_req", 32'(dmem_req), 32'd0);
        end else begin
            for (int k = 0; k < 300; k++) begin
                dmem_ack = (k == v.delay);
                @(negedge clk);
                check("req_held", 32'(dmem_req), 32'd1);
                if (k == 0) begin
                    check("addr", dmem_addr, v.addr);
                    check("we", 32'(dmem_we), 32'(v.we));
                    check("wstrb", 32'(dmem_wstrb), 32'(v.wstrb));
                    if (v.we) check("wdata", dmem_wdata, v.wdata);
                end
                check("stall_access", 32'(stall_out), 32'((k != v.delay) && (k != TO - 1)));
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (k == v.delay || k == TO - 1) break;
                if (k == 299) check("access_bound", 32'd0, 32'd1);
            end
            @(negedge clk);
            check("req_dropped", 32'(dmem_req), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        check({tag, "_instr"}, instruction_out, 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_errs"}, 32'({mem_err, bus_err}), 32'd0);
    endtask

    // Scoreboard consumer: every valid_out cycle must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid_out actual=1 expected=0 instr=%h t=%0t", instruction_out, $time);
            end else begin
                mon_e = sb.pop_front();
                $display("wb instr=%h wb_data=%h wb_en=%0d mem_err=%0d bus_err=%0d",
                         instruction_out, wb_data, wb_en, mem_err, bus_err);
                check("instr_out", instruction_out, mon_e.instr);
                check("rd_out", 32'(rd_out), 32'(mon_e.instr[11:7]));
                if (mon_e.chk_data) check("wb_data", wb_data, mon_e.wb);
                check("wb_en", 32'(wb_en), 32'(mon_e.wb_en));
                check("mem_err", 32'(mem_err), 32'(mon_e.merr));
                check("bus_err", 32'(bus_err), 32'(mon_e.berr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(itype(3'b000, 5'd3, 7'b0010011), 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 1, 1, 0, 0);
        vt[1]  = mk(itype(3'b000, 5'd0, 7'b0010011), 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7, 1, 0, 0, 0);
        vt[2]  = mk(itype(3'b000, 5'd9, 7'b1100011), 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 1, 0, 0, 0);
        vt[3]  = mk(itype(3'b000, 5'd4, 7'b0000011), 32'h103, 0, 32'h80FF_1234, 3, 1, 32'h100, 4'b0000, 0, 0,
                    32'hFFFF_FF80, 1, 1, 0, 0);
        vt[4]  = mk(itype(3'b100, 5'd4, 7'b0000011), 32'h102, 0, 32'h80FF_1234, 0, 1, 32'h100, 4'b0000, 0, 0,
                    32'h0000_00FF, 1, 1, 0, 0);
        vt[5]  = mk(itype(3'b001, 5'd6, 7'b0000011), 32'h202, 0, 32'h80FF_1234, 1, 1, 32'h200, 4'b0000, 0, 0,
                    32'hFFFF_80FF, 1, 1, 0, 0);
        vt[6]  = mk(itype(3'b101, 5'd6, 7'b0000011), 32'h200, 0, 32'h0000_9ABC, 0, 1, 32'h200, 4'b0000, 0, 0,
                    32'h0000_9ABC, 1, 1, 0, 0);
        vt[7]  = mk(itype(3'b010, 5'd7, 7'b0000011), 32'h300, 0, 32'hDEAD_BEEF, 2, 1, 32'h300, 4'b0000, 0, 0,
                    32'hDEAD_BEEF, 1, 1, 0, 0);
        vt[8]  = mk(stype(3'b001), 32'h202, 32'h0000_BEEF, 0, 0, 1, 32'h200, 4'b1100, 1, 32'hBEEF_BEEF,
                    0, 0, 0, 0, 0);
        vt[9]  = mk(stype(3'b000), 32'h401, 32'h1234_56A5, 0, 1, 1, 32'h400, 4'b0010, 1, 32'hA5A5_A5A5,
                    0, 0, 0, 0, 0);
        vt[10] = mk(stype(3'b010), 32'h500, 32'hCAFE_F00D, 0, 0, 1, 32'h500, 4'b1111, 1, 32'hCAFE_F00D,
                    0, 0, 0, 0, 0);
        vt[11] = mk(itype(3'b010, 5'd8, 7'b0000011), 32'h600, 0, 0, -1, 1, 32'h600, 4'b0000, 0, 0,
                    0, 0, 0, 0, 1);
        vt[12] = mk(itype(3'b010, 5'd9, 7'b0000011), 32'h604, 0, 32'h1122_3344, TO - 1, 1, 32'h604, 4'b0000, 0, 0,
                    32'h1122_3344, 1, 1, 0, 0);
        vt[13] = mk(stype(3'b011), 32'h700, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[14] = mk(itype(3'b110, 5'd5, 7'b0000011), 32'h704, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        vt[15] = mk(itype(3'b010, 5'd10, 7'b0000011), 32'h102, 0, 32'h5566_7788, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 1, 0);
`else
        vt[15] = mk(itype(3'b010, 5'd10, 7'b0000011), 32'h102, 0, 32'h5566_7788, 0, 1, 32'h100, 4'b0000, 0, 0,
                    32'h5566_7788, 1, 1, 0, 0);
`endif
        vt[16] = mk(itype(3'b000, 5'd1, 7'b0110111), 32'hABCD_E000, 0, 0, 0, 0, 0, 0, 0, 0,
                    32'hABCD_E000, 1, 1, 0, 0);

        rst = 1'b1; valid_in = 1'b0; dmem_ack = 1'b0;
        instruction_in = '0; alu_in = '0; mem_data_in = '0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        check("reset_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

        // Back-to-back pass-through: two single-cycle valid_out pulses.
        $display("seq back_to_back");
        push_exp(itype(3'b000, 5'd2, 7'b0010011), 32'h11, 1, 1, 0, 0);
        push_exp(itype(3'b000, 5'd3, 7'b0110011), 32'h22, 1, 1, 0, 0);
        @(posedge clk); #1;
        valid_in = 1'b1; instruction_in = itype(3'b000, 5'd2, 7'b0010011); alu_in = 32'h11;
        @(posedge clk); #1;
        instruction_in = itype(3'b000, 5'd3, 7'b0110011); alu_in = 32'h22;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;

        // Reset while ACCESS is outstanding; an ack right after must be ignored.
        $display("seq reset_mid_access");
        valid_in = 1'b1; instruction_in = itype(3'b010, 5'd11, 7'b0000011); alu_in = 32'h800;
        @(posedge clk); #1;
        valid_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_pre_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_reset_state("rst_mid");
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_valid", 32'(valid_out), 32'd0);
        check("late_ack_req", 32'(dmem_req), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
